acc_cpu_controller: RTL and testbench

Synthesizable fetch/decode/execute controller for the 32-bit accumulator CPU. Sequences the large single-port synchronous RAM and the 32-bit ALU, owning PC, IR, MBR and AC. Replaces bench-driven sequencing with a Moore state machine, so the CPU top is controller + RAM + ALU with a tri-state data bus.

---
 rtl/acc_cpu_controller.sv | 193 +++++++++++++++++++
 tb/tb_acc_cpu_controller.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_controller.sv
// Fetch/decode/execute sequencer for the 32-bit accumulator CPU.
// Owns PC, IR, MBR and AC; RAM and ALU controls are Moore decodes of the state register.
module acc_cpu_controller #(
    parameter int                    ADDR_WIDTH = 28,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] alu_left,
    output logic [DATA_WIDTH-1:0] alu_right,
    output logic [3:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac,
    output logic [DATA_WIDTH-1:0] ir,
    output logic                  halted
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH_RD,
        S_DECODE,
        S_MEM_RD,
        S_MEM_LATCH,
        S_WB,
        S_STORE,
        S_EXEC,
        S_HALT
    } ctrlState_e;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_HALT  = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_CLEAR = 4'h4;
    localparam logic [3:0] OP_SKIP  = 4'h5;
    localparam logic [3:0] OP_JUMP  = 4'h6;
    localparam logic [3:0] OP_ADDI  = 4'h7;
    localparam logic [3:0] ALU_ADD  = 4'b0010;

    ctrlState_e            r_state;
    ctrlState_e            w_stateNext;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_ac;
    logic [DATA_WIDTH-1:0] r_ir;
    logic [DATA_WIDTH-1:0] r_mbr;
    logic [3:0]            w_opcode;
    logic [ADDR_WIDTH-1:0] w_operand;
    logic [DATA_WIDTH-1:0] w_immediate;
    logic [ADDR_WIDTH-1:0] w_pcInc;
    logic                  w_acZero;
    logic                  w_acNeg;
    logic                  w_skipTaken;

    assign w_opcode    = r_ir[DATA_WIDTH-1 -: 4];
    assign w_operand   = r_ir[ADDR_WIDTH-1:0];
    assign w_immediate = {{(DATA_WIDTH-8){1'b0}}, r_ir[DATA_WIDTH-5 -: 8]};
    assign w_pcInc     = r_pc + ADDR_WIDTH'(1);
    assign w_acZero    = (r_ac == '0);
    assign w_acNeg     = r_ac[DATA_WIDTH-1];

    // Only codes 010, 000 and 100 can skip; every other code falls through.
    always_comb begin
        w_skipTaken = 1'b0;
        case (r_ir[2:0])
            3'b010:  w_skipTaken = w_acZero;
            3'b000:  w_skipTaken = w_acNeg;
            3'b100:  w_skipTaken = !w_acNeg && !w_acZero;
            default: w_skipTaken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:      if (run) w_stateNext = S_FETCH;
            S_FETCH:     w_stateNext = S_FETCH_RD;
            S_FETCH_RD:  w_stateNext = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_ADD, OP_LOAD: w_stateNext = S_MEM_RD;
                    OP_STORE:        w_stateNext = S_STORE;
                    OP_HALT:         w_stateNext = S_HALT;
                    default:         w_stateNext = S_EXEC;
                endcase
            end
            S_MEM_RD:    w_stateNext = S_MEM_LATCH;
            S_MEM_LATCH: w_stateNext = S_WB;
            S_WB, S_STORE, S_EXEC: w_stateNext = run ? S_FETCH : S_IDLE;
            S_HALT:      w_stateNext = S_HALT;
            default:     w_stateNext = S_IDLE;
        endcase
    end

    // Bus and ALU drive depends on state and held registers only, so reset silences it at once.
    always_comb begin
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_cs      = 1'b0;
        mem_we      = 1'b0;
        mem_oe      = 1'b0;
        alu_left    = '0;
        alu_right   = '0;
        alu_control = 4'b0000;
        case (r_state)
            S_FETCH, S_FETCH_RD: begin
                mem_addr = r_pc;
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
            end
            S_MEM_RD, S_MEM_LATCH: begin
                mem_addr = w_operand;
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
            end
            S_STORE: begin
                mem_addr  = w_operand;
                mem_wdata = r_ac;
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
            end
            S_WB: begin
                if (w_opcode == OP_ADD) begin
                    alu_left    = r_ac;
                    alu_right   = r_mbr;
                    alu_control = ALU_ADD;
                end
            end
            S_EXEC: begin
                if (w_opcode == OP_ADDI) begin
                    alu_left    = r_ac;
                    alu_right   = w_immediate;
                    alu_control = ALU_ADD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_ac  <= '0;
            r_ir  <= '0;
            r_mbr <= '0;
        end else begin
            case (r_state)
                S_FETCH_RD: begin
                    r_ir <= mem_rdata;
                    r_pc <= w_pcInc;
                end
                S_MEM_LATCH: r_mbr <= mem_rdata;
                S_WB: begin
                    if (w_opcode == OP_ADD) r_ac <= alu_out;
                    else                    r_ac <= r_mbr;
                end
                S_EXEC: begin
                    case (w_opcode)
                        OP_CLEAR: r_ac <= '0;
                        OP_SKIP:  if (w_skipTaken) r_pc <= w_pcInc;
                        OP_JUMP:  r_pc <= w_operand;
                        OP_ADDI:  r_ac <= alu_out;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign pc     = r_pc;
    assign ac     = r_ac;
    assign ir     = r_ir;
    assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_acc_cpu_controller.sv
// Bench for acc_cpu_controller: RAM and ALU models around the DUT, an instruction-level
// reference model checked every cycle, plus directed programs with literal expectations.
module tb_acc_cpu_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [27:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_cs, mem_we, mem_oe;
    logic [31:0] alu_left, alu_right, alu_out;
    logic [3:0]  alu_control;
    logic [27:0] pc;
    logic [31:0] ac, ir;
    logic        halted;

    int checkCount = 0;
    int errorCount = 0;

    acc_cpu_controller #(.ADDR_WIDTH(28), .DATA_WIDTH(32), .RESET_PC(28'h100)) dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .alu_left(alu_left), .alu_right(alu_right), .alu_control(alu_control),
        .alu_out(alu_out), .pc(pc), .ac(ac), .ir(ir), .halted(halted)
    );

    always #5 clk = ~clk;

    assign alu_out = (alu_control == 4'b0010) ? alu_left + alu_right : 32'd0;

    // Sparse synchronous RAM: read data appears the cycle after the address is presented.
    logic [31:0] ram [int unsigned];
    logic [31:0] rdataReg = 32'd0;
    assign mem_rdata = rdataReg;

    function automatic logic [31:0] ramRead(input logic [27:0] a);
        return ram.exists(32'(a)) ? ram[32'(a)] : 32'd0;
    endfunction

    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[32'(mem_addr)] = mem_wdata;
        if (mem_cs && mem_oe) rdataReg <= ramRead(mem_addr);
    end

    int          weCount = 0;
    logic [27:0] weAddr = '0;
    logic [31:0] weData = '0;
    always @(negedge clk) begin
        if (mem_we) begin
            weCount++;
            weAddr = mem_addr;
            weData = mem_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Instruction-level reference model
    logic [31:0] mMem [int unsigned];
    logic [27:0] mPc = 28'h100;
    logic [31:0] mAc = 32'd0;
    bit          mHalted = 1'b0;
    int          expCycles = 0;
    bit          expMemRd, expStore, expAlu;
    logic [27:0] expMemAddr, expStoreAddr;
    logic [31:0] expStoreData, expAluLeft, expAluRight;
    bit          modelOn = 1'b0;

    function automatic logic [31:0] mRead(input logic [27:0] a);
        return mMem.exists(32'(a)) ? mMem[32'(a)] : 32'd0;
    endfunction

    task automatic modelStep();
        logic [31:0] instr;
        logic [27:0] operand;
        bit          doSkip;
        instr = mRead(mPc);
        operand = instr[27:0];
        expMemRd = 0; expStore = 0; expAlu = 0;
        expCycles = 4;
        mPc = mPc + 28'd1;
        case (instr[31:28])
            4'h0: begin
                expMemRd = 1; expMemAddr = operand; expCycles = 6;
                expAlu = 1; expAluLeft = mAc; expAluRight = mRead(operand);
                mAc = mAc + expAluRight;
            end
            4'h1: begin mHalted = 1; expCycles = 3; end
            4'h2: begin
                expMemRd = 1; expMemAddr = operand; expCycles = 6;
                mAc = mRead(operand);
            end
            4'h3: begin
                expStore = 1; expStoreAddr = operand; expStoreData = mAc;
                mMem[32'(operand)] = mAc;
            end
            4'h4: mAc = 32'd0;
            4'h5: begin
                doSkip = (instr[2:0] == 3'b010 && mAc == 0) ||
                         (instr[2:0] == 3'b000 && $signed(mAc) < 0) ||
                         (instr[2:0] == 3'b100 && $signed(mAc) > 0);
                if (doSkip) mPc = mPc + 28'd1;
            end
            4'h6: mPc = operand;
            4'h7: begin
                expAlu = 1; expAluLeft = mAc; expAluRight = {24'd0, instr[27:20]};
                mAc = mAc + expAluRight;
            end
            default: ;
        endcase
    endtask

    // Per-cycle comparison of DUT outputs against the reference model.
    int cnt = 0;
    bit haveInstr = 0, prevOe = 0, sawRunLow = 0, haltSeen = 0;
    always @(negedge clk) begin
        if (!modelOn || reset) begin
            haveInstr = 0; prevOe = 0; sawRunLow = 0; haltSeen = 0; cnt = 0;
        end else begin
            if (!run) sawRunLow = 1;
            checkOutput("we/oe exclusive", {31'd0, mem_we && mem_oe}, 32'd0);
            if (mem_cs && mem_oe && !prevOe && (!haveInstr || cnt >= expCycles)) begin
                if (haveInstr && !sawRunLow) checkOutput("instr cycles", 32'(cnt), 32'(expCycles));
                checkOutput("fetch while halted", {31'd0, mHalted}, 32'd0);
                checkOutput("fetch addr", 32'(mem_addr), 32'(mPc));
                checkOutput("pc at fetch", 32'(pc), 32'(mPc));
                checkOutput("ac at fetch", ac, mAc);
                cnt = 1;
                sawRunLow = !run;
                haveInstr = 1;
                modelStep();
            end else begin
                cnt++;
                if (mem_cs && mem_oe && !prevOe) begin
                    checkOutput("operand read expected", {31'd0, expMemRd}, 32'd1);
                    checkOutput("operand addr", 32'(mem_addr), 32'(expMemAddr));
                    checkOutput("operand read cycle", 32'(cnt), 32'd4);
                end
            end
            if (mem_we) begin
                checkOutput("store expected", {31'd0, expStore}, 32'd1);
                checkOutput("store addr", 32'(mem_addr), 32'(expStoreAddr));
                checkOutput("store data", mem_wdata, expStoreData);
                checkOutput("store cycle", 32'(cnt), 32'd4);
            end
            if (alu_control != 4'd0) begin
                checkOutput("alu expected", {31'd0, expAlu}, 32'd1);
                checkOutput("alu control", {28'd0, alu_control}, 32'd2);
                checkOutput("alu left", alu_left, expAluLeft);
                checkOutput("alu right", alu_right, expAluRight);
                checkOutput("alu cycle", 32'(cnt), 32'(expCycles));
            end
            if (halted) begin
                if (!haltSeen) begin
                    checkOutput("halt expected", {31'd0, mHalted}, 32'd1);
                    checkOutput("halt entry cycle", 32'(cnt), 32'd4);
                    checkOutput("pc at halt", 32'(pc), 32'(mPc));
                    haltSeen = 1;
                end
                checkOutput("halted bus idle", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
            end
            prevOe = mem_cs && mem_oe;
        end
    end

    task automatic clearMem();
        ram.delete();
        mMem.delete();
    endtask

    task automatic loadWord(input logic [27:0] a, input logic [31:0] d);
        ram[32'(a)] = d;
        mMem[32'(a)] = d;
    endtask

    task automatic applyStimulus(input bit useModel, input bit startRun);
        modelOn = 0;
        reset = 1;
        run = 0;
        mPc = 28'h100; mAc = 32'd0; mHalted = 0; expCycles = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        modelOn = useModel;
        if (startRun) begin
            @(negedge clk);
            run = 1;
        end
    endtask

    task automatic waitHalt(input int limit);
        int n = 0;
        while (!halted && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("halt reached", {31'd0, halted}, 32'd1);
    endtask

    logic [31:0] fibProg [19] = '{
        32'h2000010D, 32'h0000010E, 32'h3000010F, 32'h2000010E, 32'h3000010D,
        32'h2000010F, 32'h3000010E, 32'h20000110, 32'h00000111, 32'h30000110,
        32'h50000002, 32'h60000100, 32'h10000000,
        32'h00000001, 32'h00000000, 32'h00000000, 32'h00000009, 32'hFFFFFFFF, 32'h00000000
    };

    initial begin
        // Reset values with run low, then first fetch
        clearMem();
        loadWord(28'h100, 32'h10000000);
        applyStimulus(1, 0);
        repeat (2) @(negedge clk);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset mem_cs", {31'd0, mem_cs}, 32'd0);
        checkOutput("reset mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("reset mem_oe", {31'd0, mem_oe}, 32'd0);
        checkOutput("reset alu_left", alu_left, 32'd0);
        checkOutput("reset alu_right", alu_right, 32'd0);
        checkOutput("reset alu_control", {28'd0, alu_control}, 32'd0);
        checkOutput("reset pc", 32'(pc), 32'h100);
        checkOutput("reset ac", ac, 32'd0);
        checkOutput("reset ir", ir, 32'd0);
        checkOutput("reset halted", {31'd0, halted}, 32'd0);
        run = 1;
        @(negedge clk);
        checkOutput("first fetch addr", 32'(mem_addr), 32'h100);
        checkOutput("first fetch cs/oe/we", {29'd0, mem_cs, mem_oe, mem_we}, 32'b110);
        waitHalt(50);
        checkOutput("halt-only pc", 32'(pc), 32'h101);

        // LOAD then ADD of the same word
        clearMem();
        loadWord(28'h100, 32'h20000110);
        loadWord(28'h101, 32'h00000110);
        loadWord(28'h102, 32'h10000000);
        loadWord(28'h110, 32'd7);
        applyStimulus(1, 1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        checkOutput("load ac after 6", ac, 32'd7);
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("add ac after 12", ac, 32'd14);
        checkOutput("pc after 12", 32'(pc), 32'h102);
        waitHalt(50);
        checkOutput("model ac load/add", mAc, 32'd14);

        // ADDI, STORE, no-op, CLEAR, LOAD readback
        clearMem();
        loadWord(28'h100, 32'h70500000);
        loadWord(28'h101, 32'h3000010E);
        loadWord(28'h102, 32'h8ABCDEF0);
        loadWord(28'h103, 32'h40000000);
        loadWord(28'h104, 32'h2000010E);
        loadWord(28'h105, 32'h10000000);
        weCount = 0;
        applyStimulus(1, 1);
        waitHalt(100);
        checkOutput("store we cycles", 32'(weCount), 32'd1);
        checkOutput("store we addr", 32'(weAddr), 32'h10E);
        checkOutput("store we data", weData, 32'd5);
        checkOutput("store readback ac", ac, 32'd5);
        checkOutput("store ram word", ramRead(28'h10E), 32'd5);
        checkOutput("store program pc", 32'(pc), 32'h106);

        // SKIP 010 with ac=0 skips
        clearMem();
        loadWord(28'h100, 32'h50000002);
        loadWord(28'h101, 32'h10000000);
        loadWord(28'h102, 32'h10000000);
        applyStimulus(1, 1);
        waitHalt(50);
        checkOutput("skip ac=0 pc", 32'(pc), 32'h103);

        // SKIP 010 with ac=1 falls through
        clearMem();
        loadWord(28'h100, 32'h70100000);
        loadWord(28'h101, 32'h50000002);
        loadWord(28'h102, 32'h10000000);
        loadWord(28'h103, 32'h10000000);
        applyStimulus(1, 1);
        waitHalt(50);
        checkOutput("skip ac=1 pc", 32'(pc), 32'h103);

        // SKIP 000 with negative ac skips
        clearMem();
        loadWord(28'h100, 32'h20000110);
        loadWord(28'h101, 32'h50000000);
        loadWord(28'h102, 32'h10000000);
        loadWord(28'h103, 32'h10000000);
        loadWord(28'h110, 32'hFFFFFFFF);
        applyStimulus(1, 1);
        waitHalt(50);
        checkOutput("skip negative pc", 32'(pc), 32'h104);
        checkOutput("skip negative ac", ac, 32'hFFFFFFFF);

        // SKIP 100 with positive ac skips; code 001 never skips
        clearMem();
        loadWord(28'h100, 32'h70100000);
        loadWord(28'h101, 32'h50000004);
        loadWord(28'h102, 32'h10000000);
        loadWord(28'h103, 32'h50000001);
        loadWord(28'h104, 32'h10000000);
        loadWord(28'h105, 32'h10000000);
        applyStimulus(1, 1);
        waitHalt(50);
        checkOutput("skip positive/never pc", 32'(pc), 32'h105);

        // Fibonacci loop
        clearMem();
        for (int i = 0; i < 19; i++) loadWord(28'h100 + 28'(i), fibProg[i]);
        applyStimulus(1, 1);
        waitHalt(3000);
        checkOutput("fib halt pc", 32'(pc), 32'h10D);
        checkOutput("fib final term", ramRead(28'h10F), 32'd34);
        checkOutput("fib model term", mRead(28'h10F), 32'd34);

        // Pause at instruction boundary
        clearMem();
        loadWord(28'h100, 32'h70300000);
        loadWord(28'h101, 32'h70400000);
        loadWord(28'h102, 32'h10000000);
        applyStimulus(1, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        run = 0;
        repeat (6) @(negedge clk);
        checkOutput("paused cs", {31'd0, mem_cs}, 32'd0);
        checkOutput("paused ac", ac, 32'd3);
        checkOutput("paused pc", 32'(pc), 32'h101);
        run = 1;
        waitHalt(100);
        checkOutput("resume ac", ac, 32'd7);

        // Asynchronous reset during MEM_LATCH of ADD
        clearMem();
        loadWord(28'h100, 32'h00000110);
        loadWord(28'h101, 32'h10000000);
        loadWord(28'h110, 32'd3);
        applyStimulus(0, 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("mem_latch addr", 32'(mem_addr), 32'h110);
        checkOutput("mem_latch ir", ir, 32'h00000110);
        reset = 1;
        #1;
        checkOutput("async reset cs/oe/we", {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
        checkOutput("async reset addr", 32'(mem_addr), 32'd0);
        checkOutput("async reset pc", 32'(pc), 32'h100);
        checkOutput("async reset ir", ir, 32'd0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        checkOutput("refetch addr", 32'(mem_addr), 32'h100);
        checkOutput("refetch cs", {31'd0, mem_cs}, 32'd1);
        waitHalt(50);
        checkOutput("rerun ac", ac, 32'd3);

        // JUMP to top of address space, PC wraps on fetch
        clearMem();
        loadWord(28'h100, 32'h6FFFFFFF);
        loadWord(28'hFFFFFFF, 32'h10000000);
        applyStimulus(1, 1);
        waitHalt(50);
        checkOutput("wrap pc", 32'(pc), 32'd0);
        checkOutput("model wrap pc", 32'(mPc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
